// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional LOADER_CHECKSUM_EN build adds the CHK trailer state.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    PAYLOAD = 3'd2,
    FIN     = 3'd3,
    CHK     = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BITS       = 8 * HDR_BYTES;

  // States in which a stream byte may be taken.
  function automatic logic accepts_input(state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == PAYLOAD) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Stream input plus imem write port and status of the loader.
// Handshake: a byte moves on a rising edge where in_valid & in_ready are both 1.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] write_address;
  logic [7:0]  write_data;
  logic        We;
  logic        pc_enable;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output in_data, in_valid,
    input  in_ready, write_address, write_data, We, pc_enable, busy, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_address, write_data, We, pc_enable, busy, done, error
  );
endinterface

// File: rtl/imem_loader_csum8.sv
// 8-bit modulo-256 running sum of payload bytes, cleared at frame start.
module loader_csum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = 8'h00;
    else if (en_i) sum_d = sum_q + byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: 16-bit word count then payload, one imem byte write per cycle.
// Define LOADER_CHECKSUM_EN to require an 8-bit sum trailer before releasing the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic      clk,
  input  logic      rst,
  imem_loader_if.slave bus,
  output state_t    state_o
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD * MAX_WORDS) + 1;

  state_t             state_q, state_d;
  logic [7:0]         count_hi_q, count_hi_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   left_q, left_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               we_q, we_d;
  logic               rdy_q;
  logic               xfer;
  logic [HDR_BITS-1:0] hdr_count;

  assign xfer      = bus.in_valid & rdy_q;
  assign hdr_count = {count_hi_q, bus.in_data};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  loader_csum8 u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  ((state_q == HDR_LO) && xfer),
    .en_i   ((state_q == PAYLOAD) && xfer),
    .byte_i (bus.in_data),
    .sum_o  (sum)
  );
`endif

  always_comb begin
    state_d    = state_q;
    count_hi_d = count_hi_q;
    idx_d      = idx_q;
    left_d     = left_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          count_hi_d = bus.in_data;
          state_d    = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          if (32'(hdr_count) > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else if (hdr_count == '0) begin
            state_d = FIN;
          end else begin
            state_d = PAYLOAD;
            idx_d   = '0;
            left_d  = IDX_W'(32'(hdr_count) * 32'(BYTES_PER_WORD));
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          we_d   = 1'b1;
          data_d = bus.in_data;
          // Address wraps mod 2^32 by plain 32-bit addition.
          addr_d = BASE_ADDR + 32'(idx_q);
          idx_d  = idx_q + 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == IDX_W'(1)) state_d = FIN;
        end
      end
      FIN: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = CHK;
`else
        state_d = RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (bus.in_data == sum) ? RUN : ERR;
      end
`endif
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_HI;
      count_hi_q <= 8'h00;
      idx_q      <= '0;
      left_q     <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= 8'h00;
      we_q       <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_hi_q <= count_hi_d;
      idx_q      <= idx_d;
      left_q     <= left_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      // Registered decode of the next state keeps in_ready low through the reset cycle.
      rdy_q      <= accepts_input(state_d);
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
  assign bus.We            = we_q;
  assign bus.pc_enable     = (state_q == RUN);
  assign bus.done          = (state_q == RUN);
  assign bus.error         = (state_q == ERR);
  assign bus.busy          = (state_q == HDR_LO) || (state_q == PAYLOAD) ||
                             (state_q == FIN)    || (state_q == CHK);
  assign state_o           = state_q;
endmodule
